// File: rtl/fp_operand_assembler.sv
// fp_operand_assembler
// Pops bytes from the upstream 8-bit FIFO, packs them big-endian into two
// binary32 operands (A = bytes 0..3, B = bytes 4..7), classifies each one and
// offers the pair to the FP core over a valid/ready handshake.
//
// Ports
//   clk, reset    rising-edge clock, asynchronous active-high reset
//   flush         synchronous discard of any partial or presented pair
//   fifo_empty    FIFO empty flag
//   fifo_data     FIFO read data, valid the cycle after a pop
//   fifo_rd_en    pop request (combinational)
//   op_a, op_b    assembled operands
//   a_class       class of op_a (combinational from op_a)
//   b_class       class of op_b (combinational from op_b)
//   out_valid     pair presented to the FP core
//   out_ready     FP core accepts the pair
//   byte_cnt      bytes captured into the current pair, 0..8
module fp_operand_assembler #(
  parameter int unsigned OP_BYTES  = 4,
  parameter int unsigned NUM_BYTES = 2 * OP_BYTES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    fifo_empty,
  input  logic [7:0]              fifo_data,
  output logic                    fifo_rd_en,
  output logic [8*OP_BYTES-1:0]   op_a,
  output logic [8*OP_BYTES-1:0]   op_b,
  output logic [2:0]              a_class,
  output logic [2:0]              b_class,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              byte_cnt
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] PAIR_LEN = CNT_W'(NUM_BYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

  typedef enum logic {
    LOAD    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   req_cnt;
  logic               rd_pending;

  // Binary32 class: 000 zero, 001 subnormal, 010 normal, 011 inf, 100 qNaN, 101 sNaN
  function automatic logic [2:0] classify(input logic [31:0] x);
    logic [7:0]  e;
    logic [22:0] m;
    e = x[30:23];
    m = x[22:0];
    if (e == 8'h00)      classify = (m == 23'd0) ? 3'b000 : 3'b001;
    else if (e != 8'hFF) classify = 3'b010;
    else if (m == 23'd0) classify = 3'b011;
    else if (m[22])      classify = 3'b100;
    else                 classify = 3'b101;
  endfunction

  assign a_class = classify(op_a);
  assign b_class = classify(op_b);

  // Pop only while collecting, with data available and pops still owed
  assign fifo_rd_en = !reset && (state == LOAD) && !fifo_empty &&
                      (req_cnt < PAIR_LEN) && !flush;

  // Collection / presentation state machine with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      req_cnt    <= '0;
      byte_cnt   <= '0;
      rd_pending <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      out_valid  <= 1'b0;
    end else if (flush) begin
      // In-flight byte is dropped by clearing rd_pending; op regs keep stale data
      state      <= LOAD;
      req_cnt    <= '0;
      byte_cnt   <= '0;
      rd_pending <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      rd_pending <= fifo_rd_en;
      if (fifo_rd_en) req_cnt <= req_cnt + CNT_W'(1);

      unique case (state)
        LOAD: begin
          if (rd_pending) begin
            unique case (byte_cnt[2:0])
              3'd0: op_a[31:24] <= fifo_data;
              3'd1: op_a[23:16] <= fifo_data;
              3'd2: op_a[15:8]  <= fifo_data;
              3'd3: op_a[7:0]   <= fifo_data;
              3'd4: op_b[31:24] <= fifo_data;
              3'd5: op_b[23:16] <= fifo_data;
              3'd6: op_b[15:8]  <= fifo_data;
              3'd7: op_b[7:0]   <= fifo_data;
              default: ;
            endcase
            byte_cnt <= byte_cnt + CNT_W'(1);
            if (byte_cnt == LAST_IDX) begin
              state     <= PRESENT;
              out_valid <= 1'b1;
            end
          end
        end
        PRESENT: begin
          if (out_ready) begin
            state     <= LOAD;
            req_cnt   <= '0;
            byte_cnt  <= '0;
            out_valid <= 1'b0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_operand_assembler.sv
// Scoreboard bench for fp_operand_assembler: a behavioural byte FIFO feeds the
// DUT, expected pairs are queued as bytes are pushed, and a monitor pops and
// compares each pair at its handshake.
module tb_fp_operand_assembler;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd_en;
  logic [31:0] op_a, op_b;
  logic [2:0]  a_class, b_class;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  byte_cnt;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ca;
    logic [2:0]  cb;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fifo_q[$];
  logic       rd_s = 1'b0;
  int         checks = 0;
  int         errors = 0;

  fp_operand_assembler dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .op_a       (op_a),
    .op_b       (op_b),
    .a_class    (a_class),
    .b_class    (b_class),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .byte_cnt   (byte_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // FIFO model: pop request sampled mid-cycle, registered data after the edge
  always @(negedge clk) rd_s = fifo_rd_en;
  always @(posedge clk) begin
    if (rd_s && fifo_q.size() > 0) begin
      fifo_data  <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Monitor: compare each accepted pair against the scoreboard
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pair got %h_%h expected none", op_a, op_b);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("op_a",    op_a,           e.a);
        chk("op_b",    op_b,           e.b);
        chk("a_class", 32'(a_class),   32'(e.ca));
        chk("b_class", 32'(b_class),   32'(e.cb));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    fifo_q.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] ca, input logic [2:0] cb,
                           input bit expect_it);
    exp_t e;
    e.a = a; e.b = b; e.ca = ca; e.cb = cb;
    if (expect_it) sb.push_back(e);
    for (int i = 3; i >= 0; i--) push_byte(a[8*i +: 8]);
    for (int i = 3; i >= 0; i--) push_byte(b[8*i +: 8]);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got %0d pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_cnt(input string name, input logic [3:0] target, input int budget);
    int n;
    n = 0;
    while (byte_cnt != target && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(byte_cnt), 32'(target));
  endtask

  initial begin
    exp_t x;
    int   n;
    reset      = 1'b1;
    flush      = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;
    out_ready  = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_byte_cnt",  32'(byte_cnt),  32'd0);
    chk("rst_op_a",      op_a,           32'd0);
    chk("rst_op_b",      op_b,           32'd0);
    chk("rst_a_class",   32'(a_class),   32'd0);
    chk("rst_rd_en",     32'(fifo_rd_en), 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // 1: normal pair at full rate, out_valid 8 cycles after first pop
    push_pair(32'h3F800000, 32'h40000000, 3'b010, 3'b010, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t1_rd_en", 32'(fifo_rd_en), 32'd1);
    end
    @(negedge clk);
    chk("t1_rd_en_done",   32'(fifo_rd_en), 32'd0);
    chk("t1_valid_early",  32'(out_valid),  32'd0);
    @(negedge clk);
    chk("t1_valid",        32'(out_valid),  32'd1);
    chk("t1_byte_cnt",     32'(byte_cnt),   32'd8);
    tick();
    wait_drain("t1_drain", 40);

    // 2: special values
    push_pair(32'h00000000, 32'h7F800000, 3'b000, 3'b011, 1'b1);
    push_pair(32'h7FC00000, 32'h7F800001, 3'b100, 3'b101, 1'b1);
    push_pair(32'h80000001, 32'hFF7FFFFF, 3'b001, 3'b010, 1'b1);
    wait_drain("t2_drain", 120);

    // 3: FIFO underflow mid-pair
    x.a = 32'hC0490FDB; x.b = 32'h00800000; x.ca = 3'b010; x.cb = 3'b010;
    sb.push_back(x);
    push_byte(8'hC0); push_byte(8'h49); push_byte(8'h0F);
    repeat (10) tick();
    chk("t3_byte_cnt_hold", 32'(byte_cnt),   32'd3);
    chk("t3_rd_en_empty",   32'(fifo_rd_en), 32'd0);
    chk("t3_valid_hold",    32'(out_valid),  32'd0);
    push_byte(8'hDB); push_byte(8'h00); push_byte(8'h80); push_byte(8'h00); push_byte(8'h00);
    wait_drain("t3_drain", 40);

    // 4: backpressure with the next pair already waiting in the FIFO
    out_ready = 1'b0;
    push_pair(32'h7FFFFFFF, 32'hFF800000, 3'b100, 3'b011, 1'b1);
    push_pair(32'h007FFFFF, 32'h7FBFFFFF, 3'b001, 3'b101, 1'b1);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_valid_held", 32'(out_valid),  32'd1);
      chk("t4_rd_en_held", 32'(fifo_rd_en), 32'd0);
      chk("t4_op_a_held",  op_a,            32'h7FFFFFFF);
      chk("t4_op_b_held",  op_b,            32'hFF800000);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_valid_drop",  32'(out_valid),  32'd0);
    chk("t4_cnt_clear",   32'(byte_cnt),   32'd0);
    chk("t4_rd_resume",   32'(fifo_rd_en), 32'd1);
    tick();
    wait_drain("t4_drain", 40);

    // 5: flush with the sixth byte in flight
    for (int i = 0; i < 6; i++) push_byte(8'hA0 + 8'(i));
    wait_cnt("t5_cnt_five", 4'd5, 40);
    flush = 1'b1;
    chk("t5_rd_masked", 32'(fifo_rd_en), 32'd0);
    tick();
    flush = 1'b0;
    chk("t5_cnt_flushed",   32'(byte_cnt),  32'd0);
    chk("t5_valid_flushed", 32'(out_valid), 32'd0);
    repeat (3) tick();
    chk("t5_inflight_drop", 32'(byte_cnt),  32'd0);
    push_pair(32'h41200000, 32'h80000000, 3'b010, 3'b000, 1'b1);
    wait_drain("t5_drain", 40);

    // 6: async reset mid-load
    push_pair(32'h12345678, 32'h9ABCDEF0, 3'b010, 3'b010, 1'b0);
    wait_cnt("t6_cnt_six", 4'd6, 40);
    reset = 1'b1;
    fifo_q.delete();
    fifo_empty = 1'b1;
    #1;
    chk("t6_valid",    32'(out_valid),  32'd0);
    chk("t6_byte_cnt", 32'(byte_cnt),   32'd0);
    chk("t6_op_a",     op_a,            32'd0);
    chk("t6_op_b",     op_b,            32'd0);
    chk("t6_rd_en",    32'(fifo_rd_en), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    push_pair(32'h3F800000, 32'hBF800000, 3'b010, 3'b010, 1'b1);
    wait_drain("t6_drain", 40);

    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
